// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - stall/flush sequencer for the 5-stage MIPS pipeline
// Memory wait states, debug halt, branch flush and hazard stall, plus saturating event counters.
module pipeline_stall_controller #(
  parameter int MEM_WAIT = 2,
  parameter int COUNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hazard_detected,
  input  logic               branch_taken,
  input  logic               mem_req,
  input  logic               halt_req,
  input  logic               cnt_clr,
  output logic               freeze_IF,
  output logic               freeze_ID,
  output logic               freeze_EXE,
  output logic               freeze_MEM,
  output logic               flush_ID,
  output logic               bubble_EXE,
  output logic               bubble_WB,
  output logic               halt_ack,
  output logic [COUNT_W-1:0] stall_count,
  output logic [COUNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {RUN, MEM_BUSY, HALTED} state_t;

  localparam bit         HAS_WAIT  = (MEM_WAIT > 0);
  localparam logic [3:0] WAIT_INIT = HAS_WAIT ? 4'(MEM_WAIT - 1) : 4'd0;

  state_t     state, state_nxt;
  logic [3:0] wcnt, wcnt_nxt;
  logic       mem_stall, run_act, halted;
  logic       f_if, f_id, f_exe, f_mem, fl_id, b_exe, b_wb;
  logic       stall_inc, flush_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      wcnt  <= 4'd0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    mem_stall = 1'b0;
    run_act   = 1'b0;
    halted    = 1'b0;
    case (state)
      RUN: begin
        if (mem_req && HAS_WAIT) begin
          mem_stall = 1'b1;
          state_nxt = MEM_BUSY;
          wcnt_nxt  = WAIT_INIT;
        end else begin
          run_act = 1'b1;
          if (halt_req) state_nxt = HALTED;
        end
      end
      MEM_BUSY: begin
        if (wcnt != 4'd0) begin
          mem_stall = 1'b1;
          wcnt_nxt  = wcnt - 4'd1;
        end else begin
          // Release cycle: mem_req still belongs to the finishing access.
          run_act   = 1'b1;
          state_nxt = halt_req ? HALTED : RUN;
        end
      end
      HALTED: begin
        halted = 1'b1;
        if (!halt_req) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    f_if  = 1'b0;
    f_id  = 1'b0;
    f_exe = 1'b0;
    f_mem = 1'b0;
    fl_id = 1'b0;
    b_exe = 1'b0;
    b_wb  = 1'b0;
    if (mem_stall || halted) begin
      f_if  = 1'b1;
      f_id  = 1'b1;
      f_exe = 1'b1;
      f_mem = 1'b1;
      b_wb  = 1'b1;
    end else if (run_act) begin
      // A taken branch makes the ID instruction wrong-path, so it beats the hazard.
      if (branch_taken) begin
        fl_id = 1'b1;
        b_exe = 1'b1;
      end else if (hazard_detected) begin
        f_if  = 1'b1;
        f_id  = 1'b1;
        b_exe = 1'b1;
      end
    end
  end

  assign freeze_IF  = rst & f_if;
  assign freeze_ID  = rst & f_id;
  assign freeze_EXE = rst & f_exe;
  assign freeze_MEM = rst & f_mem;
  assign flush_ID   = rst & fl_id;
  assign bubble_EXE = rst & b_exe;
  assign bubble_WB  = rst & b_wb;
  assign halt_ack   = rst & halted;

  assign stall_inc = f_if & ~halted;
  assign flush_inc = fl_id;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else if (cnt_clr) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_inc && (stall_count != '1)) stall_count <= stall_count + COUNT_W'(1);
      if (flush_inc && (flush_count != '1)) flush_count <= flush_count + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - directed vector bench for pipeline_stall_controller
// Three instances (MEM_WAIT 0/2/3) share stimulus; outputs packed as {fIF,fID,fEXE,fMEM,flID,bEXE,bWB,hack}.
module tb_pipeline_stall_controller;

  typedef struct {
    logic       hz;
    logic       br;
    logic       mem;
    logic       halt;
    logic [7:0] e0;
    logic [7:0] e2;
    logic [7:0] e3;
  } vec_t;

  localparam logic [7:0] NONE  = 8'b0000_0000;
  localparam logic [7:0] HAZ   = 8'b1100_0100;
  localparam logic [7:0] FLUSH = 8'b0000_1100;
  localparam logic [7:0] STALL = 8'b1111_0010;
  localparam logic [7:0] HALT  = 8'b1111_0011;

  logic clk, rst, hazard_detected, branch_taken, mem_req, halt_req, cnt_clr;
  wire [7:0]  o0, o2, o3;
  wire [15:0] s0, f0, s2, f2;
  wire [3:0]  s3, f3;

  int checks = 0;
  int errors = 0;

  pipeline_stall_controller #(.MEM_WAIT(0), .COUNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .hazard_detected(hazard_detected), .branch_taken(branch_taken),
    .mem_req(mem_req), .halt_req(halt_req), .cnt_clr(cnt_clr),
    .freeze_IF(o0[7]), .freeze_ID(o0[6]), .freeze_EXE(o0[5]), .freeze_MEM(o0[4]),
    .flush_ID(o0[3]), .bubble_EXE(o0[2]), .bubble_WB(o0[1]), .halt_ack(o0[0]),
    .stall_count(s0), .flush_count(f0));

  pipeline_stall_controller #(.MEM_WAIT(2), .COUNT_W(16)) dut2 (
    .clk(clk), .rst(rst), .hazard_detected(hazard_detected), .branch_taken(branch_taken),
    .mem_req(mem_req), .halt_req(halt_req), .cnt_clr(cnt_clr),
    .freeze_IF(o2[7]), .freeze_ID(o2[6]), .freeze_EXE(o2[5]), .freeze_MEM(o2[4]),
    .flush_ID(o2[3]), .bubble_EXE(o2[2]), .bubble_WB(o2[1]), .halt_ack(o2[0]),
    .stall_count(s2), .flush_count(f2));

  pipeline_stall_controller #(.MEM_WAIT(3), .COUNT_W(4)) dut3 (
    .clk(clk), .rst(rst), .hazard_detected(hazard_detected), .branch_taken(branch_taken),
    .mem_req(mem_req), .halt_req(halt_req), .cnt_clr(cnt_clr),
    .freeze_IF(o3[7]), .freeze_ID(o3[6]), .freeze_EXE(o3[5]), .freeze_MEM(o3[4]),
    .flush_ID(o3[3]), .bubble_EXE(o3[2]), .bubble_WB(o3[1]), .halt_ack(o3[0]),
    .stall_count(s3), .flush_count(f3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_counts(input string tag, input int es0, input int ef0,
                            input int es2, input int ef2, input int es3, input int ef3);
    chk({tag, " stall0"}, int'(s0), es0);
    chk({tag, " flush0"}, int'(f0), ef0);
    chk({tag, " stall2"}, int'(s2), es2);
    chk({tag, " flush2"}, int'(f2), ef2);
    chk({tag, " stall3"}, int'(s3), es3);
    chk({tag, " flush3"}, int'(f3), ef3);
  endtask

  task automatic cycle(input vec_t v, input string tag);
    @(negedge clk);
    hazard_detected = v.hz;
    branch_taken    = v.br;
    mem_req         = v.mem;
    halt_req        = v.halt;
    #1;
    chk({tag, " out0"}, int'(o0), int'(v.e0));
    chk({tag, " out2"}, int'(o2), int'(v.e2));
    chk({tag, " out3"}, int'(o3), int'(v.e3));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    hazard_detected = 1'b0;
    branch_taken = 1'b0;
    mem_req = 1'b0;
    halt_req = 1'b0;
    cnt_clr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  vec_t run_tbl[4];
  vec_t mem_tbl[7];
  vec_t hz_vec;

  initial begin
    run_tbl[0] = '{hz:0, br:0, mem:0, halt:0, e0:NONE,  e2:NONE,  e3:NONE};
    run_tbl[1] = '{hz:1, br:0, mem:0, halt:0, e0:HAZ,   e2:HAZ,   e3:HAZ};
    run_tbl[2] = '{hz:0, br:1, mem:0, halt:0, e0:FLUSH, e2:FLUSH, e3:FLUSH};
    run_tbl[3] = '{hz:1, br:1, mem:0, halt:0, e0:FLUSH, e2:FLUSH, e3:FLUSH};

    // dut2 releases in cycle 2, dut3 in cycle 3; dut0 ignores mem_req entirely.
    mem_tbl[0] = '{hz:0, br:0, mem:1, halt:0, e0:NONE,  e2:STALL, e3:STALL};
    mem_tbl[1] = '{hz:0, br:1, mem:1, halt:1, e0:FLUSH, e2:STALL, e3:STALL};
    mem_tbl[2] = '{hz:0, br:1, mem:1, halt:1, e0:HALT,  e2:FLUSH, e3:STALL};
    mem_tbl[3] = '{hz:0, br:1, mem:0, halt:1, e0:HALT,  e2:HALT,  e3:FLUSH};
    mem_tbl[4] = '{hz:1, br:1, mem:0, halt:1, e0:HALT,  e2:HALT,  e3:HALT};
    mem_tbl[5] = '{hz:0, br:0, mem:0, halt:0, e0:HALT,  e2:HALT,  e3:HALT};
    mem_tbl[6] = '{hz:0, br:0, mem:0, halt:0, e0:NONE,  e2:NONE,  e3:NONE};

    hz_vec = '{hz:1, br:0, mem:0, halt:0, e0:HAZ, e2:HAZ, e3:HAZ};

    rst = 1'b0;
    hazard_detected = 1'b1;
    branch_taken = 1'b1;
    mem_req = 1'b1;
    halt_req = 1'b1;
    cnt_clr = 1'b0;
    #2;
    chk("reset out0", int'(o0), 0);
    chk("reset out2", int'(o2), 0);
    chk("reset out3", int'(o3), 0);
    chk_counts("reset", 0, 0, 0, 0, 0, 0);

    do_reset();
    for (int i = 0; i < 4; i++) cycle(run_tbl[i], $sformatf("run[%0d]", i));
    @(negedge clk);
    #1;
    chk_counts("run end", 1, 2, 1, 2, 1, 2);

    do_reset();
    for (int i = 0; i < 7; i++) cycle(mem_tbl[i], $sformatf("mem[%0d]", i));
    @(negedge clk);
    #1;
    chk_counts("mem end", 0, 1, 2, 1, 3, 1);

    do_reset();
    for (int i = 0; i < 20; i++) cycle(hz_vec, $sformatf("hz[%0d]", i));
    @(negedge clk);
    #1;
    chk_counts("sat", 20, 0, 20, 0, 15, 0);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    chk_counts("clr", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(hz_vec, $sformatf("hz2[%0d]", i));
    @(negedge clk);
    #1;
    chk_counts("post clr", 3, 0, 3, 0, 3, 0);

    #2;
    rst = 1'b0;
    #1;
    chk("async rst out0", int'(o0), 0);
    chk("async rst out2", int'(o2), 0);
    chk("async rst out3", int'(o3), 0);
    chk_counts("async rst", 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
